rcc_bdcr_ctrl: RTL and testbench
================================

Name: rcc_bdcr_ctrl

Overview:
- Parametrised, fully synchronous backup-domain control register (BDCR) with byte-enabled bus writes.
- Adds an LSE startup/ready state machine and a clock-security watchdog in place of externally supplied ready/fail strobes.
- Sits between the RCC bus register decode and the LSE oscillator/RTC clock mux.

Parameters:
- RTCSEL_W, 2, rtcsel field width (1..6), at bits [8+RTCSEL_W-1:8].
- SYNC_STAGES, 2, synchroniser depth for lse_div (min 2).
- STARTUP_EDGES, 64, lse_div edges from lseon to lserdy (1..2^16-1).
- CSS_TIMEOUT, 256, clk cycles without an lse_div edge that flag a failure (2..2^16-1).

Ports:
- clk  in  1  register/FSM clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, one cycle.
- wr_be  in  3  byte enables for data[23:16], [15:8], [7:0].
- wr_data  in  24  write data.
- rd_data  out  24  current register image, combinational from flops.
- lse_div  in  1  asynchronous divided-LSE toggle from the oscillator.
- lseon  out  1  LSE enable.
- lsebyp  out  1  LSE bypass.
- lsedrv  out  2  LSE drive strength.
- rtcen  out  1  RTC clock enable.
- rtcsel  out  RTCSEL_W  RTC clock source select.
- bdrst  out  1  backup-domain software reset.
- lserdy  out  1  LSE ready.
- lsecssd  out  1  sticky CSS failure detected.
- lsecss_fail  out  1  one-cycle pulse on CSS failure.
- lsecss_irq  out  1  CSS interrupt; present only with the optional feature.

Behaviour:
- Reset is asynchronous on rst_n low. Every output and field resets to 0. FSM resets to OFF; counters reset to 0.
- Bit map:
  - 0 lseon RW; 1 lserdy RO; 2 lsebyp RW; 4:3 lsedrv RW.
  - 5 lsecsson W1S; 6 lsecssd RO.
  - 8+ rtcsel RWOnce; 15 rtcen RW; 16 bdrst RW.
  - Unused bits read 0.
- Writes take effect on the clk edge where wr_en=1, per enabled byte. Read-back reflects a write the following cycle.
- lsebyp and lsedrv are writable only while lseon=0 and the FSM is OFF. Otherwise the write is ignored.
- lsecsson: writing 1 sets it; writing 0 is ignored. Cleared only by reset, bdrst=1, or a CSS failure.
- rtcsel: writable only while its current value is 0. Once nonzero it is locked. It unlocks (and clears to 0) on a CSS failure or bdrst=1.
- bdrst=1 synchronously holds every other field at 0 and forces the FSM to OFF. The bdrst bit itself stays writable.
- Simultaneous events: a CSS failure in the same cycle as a write wins for lsecsson, rtcsel and lsecssd. bdrst in the same write as other bits wins over them.
- lse_div passes through a SYNC_STAGES flop chain. An edge detector (either polarity) gives lse_edge. Detection latency is SYNC_STAGES+1 clk.
- FSM (lserdy=1 only in READY):
  - OFF: counters are 0. lseon=1 -> STARTUP.
  - STARTUP: a 16-bit counter increments on lse_edge. Reaching STARTUP_EDGES -> READY.
  - READY: a 16-bit watchdog increments each clk, clears on lse_edge, and saturates. If lsecsson=1 and watchdog==CSS_TIMEOUT-1 with no lse_edge that cycle -> FAIL. This asserts lsecss_fail for exactly one cycle, sets lsecssd, clears lsecsson and rtcsel, and drops lserdy the next cycle.
  - FAIL: lseon stays 1 until software writes 0. lseon=0 -> OFF.
  - lseon=0 in any state -> OFF next cycle; counters cleared.
- lsecssd is sticky. It clears only on reset or bdrst.
- A watchdog in STARTUP, or with lsecsson=0, never flags a failure.

Optional Feature:
- Macro: RCC_BDCR_CSS_IRQ_EN.
- With the macro defined:
  - bit 17 lsecssie (RW) and bit 18 lsecssf (W1C) exist.
  - lsecssf sets on lsecss_fail. On a same-cycle clear and set, the set wins.
  - lsecss_irq = lsecssie & lsecssf, registered.
- Without the macro: bits 17/18 read 0, writes to them are ignored, and the lsecss_irq port is absent.

Decomposition:
- Package rcc_bdcr_pkg holds:
  - bit-position localparams for every field;
  - FSM state typedef {OFF, STARTUP, READY, FAIL}, 2-bit encoding;
  - 16-bit counter width constant.
- One sub-module: rcc_lse_edge_sync (synchroniser plus edge detect, parameter SYNC_STAGES, output lse_edge).

Test Plan:
- Reset mid-operation: reach READY, pulse rst_n low asynchronously -> all outputs 0 immediately, FSM OFF, rd_data=0.
- Startup: write lseon=1 with STARTUP_EDGES=4, then toggle lse_div every 8 clk -> lserdy rises after the 4th synchronised edge. lseon=0 -> lserdy=0 next cycle.
- rtcsel write-once: write rtcsel=2'b01 -> reads 01. Write 2'b10 -> still 01. Write bdrst=1 then 0 -> rtcsel 00. Write 2'b10 -> reads 10.
- CSS failure: in READY with lsecsson=1 and CSS_TIMEOUT=16, stop lse_div -> lsecss_fail pulses once 16 clk after the last edge. lsecssd=1, lsecsson=0, rtcsel=0, lserdy=0.
- Simultaneous: write lsecsson=1 and rtcsel=01 in the failure cycle -> both read 0, lsecssd=1. Write lsebyp while lseon=1 -> ignored.
- With RCC_BDCR_CSS_IRQ_EN: set lsecssie, trigger a failure -> lsecss_irq=1. W1C on bit 18 -> lsecss_irq=0 the next cycle.

Source files
------------

// File: rtl/rcc_bdcr_pkg.sv
// Shared constants and types for the backup-domain control register.
// Bit map, LSE state encoding and counter width.
package rcc_bdcr_pkg;

  localparam int unsigned DATA_W       = 24;
  localparam int unsigned BE_W         = 3;
  localparam int unsigned CNT_W        = 16;

  localparam int unsigned LSEON_BIT    = 0;
  localparam int unsigned LSERDY_BIT   = 1;
  localparam int unsigned LSEBYP_BIT   = 2;
  localparam int unsigned LSEDRV_LSB   = 3;
  localparam int unsigned LSEDRV_W     = 2;
  localparam int unsigned LSECSSON_BIT = 5;
  localparam int unsigned LSECSSD_BIT  = 6;
  localparam int unsigned RTCSEL_LSB   = 8;
  localparam int unsigned RTCEN_BIT    = 15;
  localparam int unsigned BDRST_BIT    = 16;
  localparam int unsigned LSECSSIE_BIT = 17;
  localparam int unsigned LSECSSF_BIT  = 18;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    STARTUP = 2'd1,
    READY   = 2'd2,
    FAIL    = 2'd3
  } lse_state_e;

endpackage

// File: rtl/rcc_lse_edge_sync.sv
// Synchronises the asynchronous divided-LSE toggle and flags either edge.
// lse_edge_o is registered: an input change shows up SYNC_STAGES+1 clocks later.
module rcc_lse_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lse_div_i,
  output logic lse_edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lse_div_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

  assign lse_edge_o = edge_q;

endmodule

// File: rtl/rcc_bdcr_ctrl.sv
// Backup-domain control register with LSE startup FSM and clock-security watchdog.
// Optional CSS interrupt (bits 17/18, lsecss_irq_o) built with RCC_BDCR_CSS_IRQ_EN.
module rcc_bdcr_ctrl
  import rcc_bdcr_pkg::*;
#(
  parameter int unsigned RTCSEL_W      = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STARTUP_EDGES = 64,
  parameter int unsigned CSS_TIMEOUT   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [BE_W-1:0]     wr_be_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                lse_div_i,
  output logic                lseon_o,
  output logic                lsebyp_o,
  output logic [LSEDRV_W-1:0] lsedrv_o,
  output logic                rtcen_o,
  output logic [RTCSEL_W-1:0] rtcsel_o,
  output logic                bdrst_o,
  output logic                lserdy_o,
  output logic                lsecssd_o,
  output logic                lsecss_fail_o
`ifdef RCC_BDCR_CSS_IRQ_EN
  ,
  output logic                lsecss_irq_o
`endif
);

  lse_state_e          state_q, state_d;
  logic [CNT_W-1:0]    start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic [CNT_W-1:0]    start_inc;
  logic                lseon_q, lseon_d;
  logic                lsebyp_q, lsebyp_d;
  logic [LSEDRV_W-1:0] lsedrv_q, lsedrv_d;
  logic                lsecsson_q, lsecsson_d;
  logic                lsecssd_q, lsecssd_d;
  logic [RTCSEL_W-1:0] rtcsel_q, rtcsel_d;
  logic                rtcen_q, rtcen_d;
  logic                bdrst_q, bdrst_d;
  logic                lserdy_q, lserdy_d;
  logic                css_fail_q, css_fail_d;
  logic                fail_c;
  logic                lse_edge;
  logic                wr_b0, wr_b1, wr_b2;
  logic                unused_wr_data;
`ifdef RCC_BDCR_CSS_IRQ_EN
  logic                lsecssie_q, lsecssie_d;
  logic                lsecssf_q, lsecssf_d;
  logic                irq_q, irq_d;
`endif

  rcc_lse_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .lse_div_i  (lse_div_i),
    .lse_edge_o (lse_edge)
  );

  assign wr_b0 = wr_en_i & wr_be_i[0];
  assign wr_b1 = wr_en_i & wr_be_i[1];
  assign wr_b2 = wr_en_i & wr_be_i[2];
  assign unused_wr_data = ^wr_data_i;

  // LSE state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and register fields
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    wdog_d      = wdog_q;
    start_inc   = start_cnt_q + CNT_W'(1);
    fail_c      = 1'b0;
    lseon_d     = lseon_q;
    lsebyp_d    = lsebyp_q;
    lsedrv_d    = lsedrv_q;
    lsecsson_d  = lsecsson_q;
    lsecssd_d   = lsecssd_q;
    rtcsel_d    = rtcsel_q;
    rtcen_d     = rtcen_q;
    bdrst_d     = bdrst_q;
`ifdef RCC_BDCR_CSS_IRQ_EN
    lsecssie_d  = lsecssie_q;
    lsecssf_d   = lsecssf_q;
`endif

    if (!lseon_q || bdrst_q) begin
      state_d     = OFF;
      start_cnt_d = '0;
      wdog_d      = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          start_cnt_d = '0;
          wdog_d      = '0;
          state_d     = STARTUP;
        end
        STARTUP: begin
          if (lse_edge) begin
            if (start_inc == CNT_W'(STARTUP_EDGES)) begin
              state_d     = READY;
              start_cnt_d = '0;
              wdog_d      = '0;
            end else begin
              start_cnt_d = start_inc;
            end
          end
        end
        READY: begin
          if (lse_edge) begin
            wdog_d = '0;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + CNT_W'(1);
          end
          // Watchdog only trips while CSS is armed and no edge arrives this cycle
          if (lsecsson_q && !lse_edge && (wdog_q == CNT_W'(CSS_TIMEOUT - 1))) begin
            fail_c  = 1'b1;
            state_d = FAIL;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: state_d = OFF;
      endcase
    end

    if (wr_b0) begin
      lseon_d = wr_data_i[LSEON_BIT];
      if (!lseon_q && (state_q == OFF)) begin
        lsebyp_d = wr_data_i[LSEBYP_BIT];
        lsedrv_d = wr_data_i[LSEDRV_LSB +: LSEDRV_W];
      end
      if (wr_data_i[LSECSSON_BIT]) begin
        lsecsson_d = 1'b1;
      end
    end
    if (wr_b1) begin
      rtcen_d = wr_data_i[RTCEN_BIT];
      if (rtcsel_q == '0) begin
        rtcsel_d = wr_data_i[RTCSEL_LSB +: RTCSEL_W];
      end
    end
    if (wr_b2) begin
      bdrst_d = wr_data_i[BDRST_BIT];
`ifdef RCC_BDCR_CSS_IRQ_EN
      lsecssie_d = wr_data_i[LSECSSIE_BIT];
      if (wr_data_i[LSECSSF_BIT]) begin
        lsecssf_d = 1'b0;
      end
`endif
    end
`ifdef RCC_BDCR_CSS_IRQ_EN
    if (css_fail_q) begin
      lsecssf_d = 1'b1;
    end
`endif

    // A failure overrides a same-cycle software write
    if (fail_c) begin
      lsecsson_d = 1'b0;
      rtcsel_d   = '0;
      lsecssd_d  = 1'b1;
    end
    css_fail_d = fail_c;

    // Backup-domain reset clears everything except itself, old or newly written
    if (bdrst_q || bdrst_d) begin
      lseon_d    = 1'b0;
      lsebyp_d   = 1'b0;
      lsedrv_d   = '0;
      lsecsson_d = 1'b0;
      lsecssd_d  = 1'b0;
      rtcsel_d   = '0;
      rtcen_d    = 1'b0;
      state_d    = OFF;
`ifdef RCC_BDCR_CSS_IRQ_EN
      lsecssie_d = 1'b0;
      lsecssf_d  = 1'b0;
`endif
    end

    lserdy_d = (state_d == READY);
`ifdef RCC_BDCR_CSS_IRQ_EN
    irq_d = lsecssie_d & lsecssf_d;
`endif
  end

  // Field and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt_q <= '0;
      wdog_q      <= '0;
      lseon_q     <= 1'b0;
      lsebyp_q    <= 1'b0;
      lsedrv_q    <= '0;
      lsecsson_q  <= 1'b0;
      lsecssd_q   <= 1'b0;
      rtcsel_q    <= '0;
      rtcen_q     <= 1'b0;
      bdrst_q     <= 1'b0;
      lserdy_q    <= 1'b0;
      css_fail_q  <= 1'b0;
`ifdef RCC_BDCR_CSS_IRQ_EN
      lsecssie_q  <= 1'b0;
      lsecssf_q   <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      start_cnt_q <= start_cnt_d;
      wdog_q      <= wdog_d;
      lseon_q     <= lseon_d;
      lsebyp_q    <= lsebyp_d;
      lsedrv_q    <= lsedrv_d;
      lsecsson_q  <= lsecsson_d;
      lsecssd_q   <= lsecssd_d;
      rtcsel_q    <= rtcsel_d;
      rtcen_q     <= rtcen_d;
      bdrst_q     <= bdrst_d;
      lserdy_q    <= lserdy_d;
      css_fail_q  <= css_fail_d;
`ifdef RCC_BDCR_CSS_IRQ_EN
      lsecssie_q  <= lsecssie_d;
      lsecssf_q   <= lsecssf_d;
      irq_q       <= irq_d;
`endif
    end
  end

  // Register image; unused bits read 0
  always_comb begin
    rd_data_o                             = '0;
    rd_data_o[LSEON_BIT]                  = lseon_q;
    rd_data_o[LSERDY_BIT]                 = lserdy_q;
    rd_data_o[LSEBYP_BIT]                 = lsebyp_q;
    rd_data_o[LSEDRV_LSB +: LSEDRV_W]     = lsedrv_q;
    rd_data_o[LSECSSON_BIT]               = lsecsson_q;
    rd_data_o[LSECSSD_BIT]                = lsecssd_q;
    rd_data_o[RTCSEL_LSB +: RTCSEL_W]     = rtcsel_q;
    rd_data_o[RTCEN_BIT]                  = rtcen_q;
    rd_data_o[BDRST_BIT]                  = bdrst_q;
`ifdef RCC_BDCR_CSS_IRQ_EN
    rd_data_o[LSECSSIE_BIT]               = lsecssie_q;
    rd_data_o[LSECSSF_BIT]                = lsecssf_q;
`endif
  end

  assign lseon_o       = lseon_q;
  assign lsebyp_o      = lsebyp_q;
  assign lsedrv_o      = lsedrv_q;
  assign rtcen_o       = rtcen_q;
  assign rtcsel_o      = rtcsel_q;
  assign bdrst_o       = bdrst_q;
  assign lserdy_o      = lserdy_q;
  assign lsecssd_o     = lsecssd_q;
  assign lsecss_fail_o = css_fail_q;
`ifdef RCC_BDCR_CSS_IRQ_EN
  assign lsecss_irq_o  = irq_q;
`endif

endmodule

// File: tb/tb_rcc_bdcr_ctrl.sv
// Directed bench for rcc_bdcr_ctrl: register vector table plus LSE startup/CSS sequences.
module tb_rcc_bdcr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_be;
  logic [23:0] wr_data;
  logic [23:0] rd_data;
  logic        lse_div;
  logic        lseon, lsebyp, rtcen, bdrst, lserdy, lsecssd, lsecss_fail;
  logic [1:0]  lsedrv;
  logic [1:0]  rtcsel;
`ifdef RCC_BDCR_CSS_IRQ_EN
  logic        lsecss_irq;
  localparam logic [23:0] IE_EXP = 24'h020000;
  localparam logic [23:0] F_EXP  = 24'h040000;
`else
  localparam logic [23:0] IE_EXP = 24'h000000;
  localparam logic [23:0] F_EXP  = 24'h000000;
`endif

  int tests = 0;
  int fails = 0;

  rcc_bdcr_ctrl #(
    .RTCSEL_W      (2),
    .SYNC_STAGES   (2),
    .STARTUP_EDGES (4),
    .CSS_TIMEOUT   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (wr_en),
    .wr_be_i       (wr_be),
    .wr_data_i     (wr_data),
    .rd_data_o     (rd_data),
    .lse_div_i     (lse_div),
    .lseon_o       (lseon),
    .lsebyp_o      (lsebyp),
    .lsedrv_o      (lsedrv),
    .rtcen_o       (rtcen),
    .rtcsel_o      (rtcsel),
    .bdrst_o       (bdrst),
    .lserdy_o      (lserdy),
    .lsecssd_o     (lsecssd),
    .lsecss_fail_o (lsecss_fail)
`ifdef RCC_BDCR_CSS_IRQ_EN
    ,
    .lsecss_irq_o  (lsecss_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  be;
    logic [23:0] data;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] be, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_be   = be;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_be   = 3'b000;
    wr_data = 24'h0;
  endtask

  // Four lse_div toggles, 8 clk apart; ready must rise exactly 4 clk after the 4th
  task automatic reach_ready(input string tag);
    for (int i = 0; i < 4; i++) begin
      lse_div = ~lse_div;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (i == 3 && c == 3) chk({tag, "_rdy_early"}, lserdy, 0);
        if (i == 3 && c == 4) chk({tag, "_rdy_rise"}, lserdy, 1);
        if (i < 3 && c == 8) chk({tag, "_rdy_low"}, lserdy, 0);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_outs"}, {lseon, lsebyp, lsedrv, rtcen, rtcsel, bdrst, lserdy, lsecssd, lsecss_fail}, 0);
`ifdef RCC_BDCR_CSS_IRQ_EN
    chk({tag, "_irq"}, lsecss_irq, 0);
`endif
  endtask

  initial begin
    int pulses;
    int first;

    vecs[0]  = '{3'b001, 24'h00001C, 24'h00001C};
    vecs[1]  = '{3'b001, 24'h00001D, 24'h00001D};
    vecs[2]  = '{3'b001, 24'h000001, 24'h00001D};
    vecs[3]  = '{3'b001, 24'h000021, 24'h00003D};
    vecs[4]  = '{3'b001, 24'h000001, 24'h00003D};
    vecs[5]  = '{3'b010, 24'h000100, 24'h00013D};
    vecs[6]  = '{3'b010, 24'h000200, 24'h00013D};
    vecs[7]  = '{3'b010, 24'h008100, 24'h00813D};
    vecs[8]  = '{3'b100, 24'h020000, 24'h00813D | IE_EXP};
    vecs[9]  = '{3'b000, 24'hFFFFFF, 24'h00813D | IE_EXP};
    vecs[10] = '{3'b100, 24'h010000, 24'h010000};
    vecs[11] = '{3'b111, 24'h00813F, 24'h000000};
    vecs[12] = '{3'b010, 24'h000200, 24'h000200};
    vecs[13] = '{3'b001, 24'h0000C6, 24'h000204};

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_be   = 3'b000;
    wr_data = 24'h0;
    lse_div = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("reset");

    for (int i = 0; i < 14; i++) begin
      bus_write(vecs[i].be, vecs[i].data);
      chk($sformatf("vec%0d", i), rd_data, vecs[i].exp);
    end

    bus_write(3'b111, 24'h010000);
    bus_write(3'b111, 24'h000000);
    chk("bdrst_clear", rd_data, 0);

    // First startup with CSS disarmed; a stalled LSE must not flag a failure
    bus_write(3'b011, 24'h000101);
    chk("startup1_wr", rd_data, 24'h000101);
    reach_ready("startup1");
    chk("startup1_rd", rd_data, 24'h000103);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (lsecss_fail) pulses++;
    end
    chk("nocss_no_fail", pulses, 0);
    chk("nocss_still_rdy", lserdy, 1);

    bus_write(3'b001, 24'h000000);
    chk("lseon_off", lseon, 0);
    tick();
    chk("lseon_off_rdy", lserdy, 0);

    bus_write(3'b100, 24'h010000);
    bus_write(3'b100, 24'h000000);
    chk("rtcsel_unlocked", rtcsel, 0);

    // Second startup with CSS armed
    bus_write(3'b101, 24'h020021);
    chk("startup2_wr", rd_data, 24'h000021 | IE_EXP);
    reach_ready("startup2");
    chk("startup2_rd", rd_data, 24'h000023 | IE_EXP);
    pulses = 0;
    for (int t = 0; t < 2; t++) begin
      lse_div = ~lse_div;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (lsecss_fail) pulses++;
      end
    end
    chk("css_alive_no_fail", pulses, 0);
    chk("css_alive_rdy", lserdy, 1);

    // Last edge, then silence; write csson/rtcsel in the failure cycle
    lse_div = ~lse_div;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (lsecss_fail) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 19) begin
        wr_en   = 1'b1;
        wr_be   = 3'b011;
        wr_data = 24'h000121;
      end
      if (k == 20) begin
        wr_en   = 1'b0;
        wr_be   = 3'b000;
        wr_data = 24'h0;
        chk("css_fail_cycle_rd", rd_data, 24'h000041 | IE_EXP);
        chk("css_fail_cycle_rtcsel", rtcsel, 0);
      end
    end
    chk("css_pulse_count", pulses, 1);
    chk("css_pulse_time", first, 20);
    chk("css_after_rd", rd_data, 24'h000041 | IE_EXP | F_EXP);
    chk("css_after_rdy", lserdy, 0);
`ifdef RCC_BDCR_CSS_IRQ_EN
    chk("irq_set", lsecss_irq, 1);
`endif

    bus_write(3'b001, 24'h000005);
    chk("fail_lsebyp_locked", rd_data, 24'h000041 | IE_EXP | F_EXP);

`ifdef RCC_BDCR_CSS_IRQ_EN
    bus_write(3'b100, 24'h060000);
    chk("irq_w1c_rd", rd_data, 24'h020041);
    chk("irq_w1c", lsecss_irq, 0);
`endif

    bus_write(3'b001, 24'h000000);
    chk("fail_to_off_rd", rd_data, 24'h000040 | IE_EXP);
    bus_write(3'b001, 24'h000001);
    reach_ready("startup3");
    chk("sticky_cssd_rd", rd_data, 24'h000043 | IE_EXP);

    // Asynchronous reset away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
